// File: rtl/dpi_stream_sequencer.sv
// rtl/dpi_stream_sequencer.sv - header/byte sequencer driving one regex matcher slice
// Optional per-packet/byte counters under `DPI_SEQ_STATS_EN.
module dpi_stream_sequencer #(
  parameter int LOAD_WAIT  = 3,
  parameter int DRAIN_WAIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hdr_vld,
  input  logic [5:0] hdr_sid,
  output logic       hdr_rdy,
  input  logic       s_vld,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_rdy,
  input  logic       cfg_we,
  input  logic [5:0] cfg_sid,
  input  logic       cfg_en,
  input  logic       cfg_clr_seen,
  output logic       load_state,
  output logic       new_stream_id,
  output logic [5:0] stream_id,
  output logic       enable,
  output logic [7:0] char_in,
  output logic       char_in_vld,
  output logic       eop,
  output logic       busy
`ifdef DPI_SEQ_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [23:0] byte_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_STREAM, S_DRAIN, S_EOP
  } state_t;

  localparam logic [7:0] LW = 8'(LOAD_WAIT);
  localparam logic [7:0] DW = 8'(DRAIN_WAIT);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt, w_cnt_next;
  logic [5:0]  r_sid;
  logic        r_en, r_new;
  logic [63:0] r_en_mask, r_seen;
  logic [7:0]  r_char;
  logic        r_char_vld;
  logic        w_beat;

  assign w_beat      = (r_state == S_STREAM) && s_vld;
  assign stream_id   = r_sid;
  assign enable      = r_en;
  assign char_in     = r_char;
  assign char_in_vld = r_char_vld;
  assign busy        = (r_state != S_IDLE);

  always_comb begin
    w_next        = r_state;
    w_cnt_next    = r_cnt;
    hdr_rdy       = 1'b0;
    s_rdy         = 1'b0;
    load_state    = 1'b0;
    new_stream_id = 1'b0;
    eop           = 1'b0;
    case (r_state)
      S_IDLE: begin
        hdr_rdy = !rst;
        if (hdr_vld) w_next = S_LOAD;
      end
      S_LOAD: begin
        load_state    = 1'b1;
        new_stream_id = r_new;
        if (LOAD_WAIT == 0) begin
          w_next = S_STREAM;
        end else begin
          w_next     = S_WAIT;
          w_cnt_next = LW;
        end
      end
      S_WAIT: begin
        if (r_cnt <= 8'd1) w_next = S_STREAM;
        else w_cnt_next = r_cnt - 8'd1;
      end
      S_STREAM: begin
        s_rdy = 1'b1;
        if (s_vld && s_last) begin
          if (DRAIN_WAIT == 0) begin
            w_next = S_EOP;
          end else begin
            w_next     = S_DRAIN;
            w_cnt_next = DW;
          end
        end
      end
      S_DRAIN: begin
        if (r_cnt <= 8'd1) w_next = S_EOP;
        else w_cnt_next = r_cnt - 8'd1;
      end
      S_EOP: begin
        eop    = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sid      <= '0;
      r_en       <= 1'b0;
      r_new      <= 1'b0;
      r_en_mask  <= '0;
      r_seen     <= '0;
      r_char     <= '0;
      r_char_vld <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_char_vld <= w_beat;
      if (w_beat) r_char <= s_data;
      // Mask is sampled before this cycle's cfg write lands, so the header sees the old value.
      if (r_state == S_IDLE && hdr_vld) begin
        r_sid <= hdr_sid;
        r_en  <= r_en_mask[hdr_sid];
        r_new <= ~r_seen[hdr_sid];
      end
      if (cfg_we) r_en_mask[cfg_sid] <= cfg_en;
      if (cfg_clr_seen) r_seen <= '0;
      else if (r_state == S_EOP && r_en) r_seen[r_sid] <= 1'b1;
    end
  end

`ifdef DPI_SEQ_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [23:0] r_byte_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_cnt  <= '0;
      r_byte_cnt <= '0;
    end else begin
      if (r_state == S_EOP) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (w_beat) r_byte_cnt <= r_byte_cnt + 24'd1;
    end
  end

  assign pkt_cnt  = r_pkt_cnt;
  assign byte_cnt = r_byte_cnt;
`endif

endmodule

// File: doc/dpi_stream_sequencer.md
# dpi_stream_sequencer

Front-end controller for one regex matcher slice of the DPI engine. It accepts a packet header carrying a 6-bit stream ID, then a byte stream, and drives the matcher's control pins (`load_state`, `new_stream_id`, `stream_id`, `enable`, `char_in`, `char_in_vld`, `eop`) in the order the matcher's registered pipeline requires. It owns the per-stream enable mask and the 64-entry "stream seen" table that decides between a fresh state and a restored state.

## Interface
Parameters:
- `LOAD_WAIT`, default 3: idle cycles between the `load_state` pulse and the first `char_in_vld`. Covers the matcher's state restore pipeline.
- `DRAIN_WAIT`, default 3: idle cycles between the last `char_in_vld` and the `eop` pulse. Covers the matcher's accept pipeline. Minimum 1.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `hdr_vld` in 1: a header is offered.
- `hdr_sid` in 6: stream ID of the offered header.
- `hdr_rdy` out 1: the sequencer accepts a header this cycle.
- `s_vld` in 1: a payload byte is offered.
- `s_data` in 8: payload byte.
- `s_last` in 1: the offered byte is the last byte of the packet.
- `s_rdy` out 1: the sequencer accepts a byte this cycle.
- `cfg_we` in 1: write strobe for the enable mask.
- `cfg_sid` in 6: stream ID to write.
- `cfg_en` in 1: value written to `en_mask[cfg_sid]`.
- `cfg_clr_seen` in 1: clear the whole seen table.
- `load_state` out 1: matcher state load strobe.
- `new_stream_id` out 1: tells the matcher to load a zero state instead of restoring.
- `stream_id` out 6: stream ID of the current packet.
- `enable` out 1: enable value for the current packet.
- `char_in` out 8: byte to the matcher.
- `char_in_vld` out 1: `char_in` is valid.
- `eop` out 1: end-of-packet strobe to the matcher.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, LOAD, WAIT, STREAM, DRAIN, EOP.
- IDLE:
  - `hdr_rdy` = 1.
  - On `hdr_vld`, latch `sid_q` ← `hdr_sid`, `en_q` ← `en_mask[hdr_sid]`, `new_q` ← ~`seen[hdr_sid]`.
  - Go to LOAD.
- LOAD: lasts 1 cycle. `load_state` = 1 and `new_stream_id` = `new_q`. Go to WAIT with the wait counter set to `LOAD_WAIT`.
- WAIT: decrement the counter. When it reaches 0, go to STREAM.
- STREAM:
  - `s_rdy` = 1.
  - Each accepted beat registers `char_in` ← `s_data` and `char_in_vld` ← 1 on the next cycle.
  - An accepted beat with `s_last` = 1 moves to DRAIN with the counter set to `DRAIN_WAIT`.
  - A zero-length packet is not supported; the first beat may carry `s_last`.
- DRAIN: decrement the counter. When it reaches 0, go to EOP.
- EOP:
  - Lasts 1 cycle. `eop` = 1.
  - If `en_q` = 1, set `seen[sid_q]` ← 1, because the matcher saves state only when enabled.
  - Return to IDLE.
- `stream_id` = `sid_q` and `enable` = `en_q` in every non-IDLE state. Both are held stable from LOAD through EOP inclusive.
- `en_mask` and `seen` are 64×1 flop arrays.
- A `cfg_we` during a packet takes effect for the next header only; `en_q` is already latched.
- `cfg_clr_seen` clears all `seen` bits.
- `cfg_clr_seen` in the same cycle as the EOP seen-set: the clear wins.
- `cfg_we` in the same cycle as the header accept for the same SID: the header sees the old mask value.

## Timing
- Values after reset:
  - FSM in IDLE.
  - `en_mask` = 0 and `seen` = 0.
  - `load_state`, `new_stream_id`, `char_in_vld`, `eop`, `busy`, `s_rdy` = 0.
  - `stream_id` = 0, `enable` = 0, `char_in` = 0.
  - `hdr_rdy` = 1 from the first cycle after reset is released.
- Header accepted at cycle T: `load_state` at T+1; first `s_rdy` at T+2+`LOAD_WAIT`.
- Byte path latency: 1 cycle from accepted beat to `char_in_vld`.
- `s_rdy` may be held high with `s_vld` low; the resulting gaps appear as `char_in_vld` = 0 cycles.
- Last beat accepted at cycle L: `eop` at L+1+`DRAIN_WAIT`; `hdr_rdy` = 1 again at L+2+`DRAIN_WAIT`.
- `hdr_rdy` is 0 in every state except IDLE. No header is taken until after the EOP cycle.
- `rst` mid-packet:
  - Immediate return to IDLE with all outputs at their reset values.
  - No `eop` is issued.
  - Tables are cleared.

## Configuration
- `DPI_SEQ_STATS_EN` defined:
  - Adds outputs `pkt_cnt[15:0]` and `byte_cnt[23:0]`.
  - `pkt_cnt` increments on each EOP cycle; `byte_cnt` increments on each accepted beat.
  - Both wrap at full scale and reset to 0.
- Macro undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- After reset, `cfg_we` for SID 5 with `cfg_en` = 1; header SID 5 with a 4-byte packet 0x41..0x44 → `load_state` with `new_stream_id` = 1, then 4 `char_in_vld` cycles with matching `char_in`. `eop` comes exactly `DRAIN_WAIT`+1 cycles after the last beat. `seen[5]` = 1.
- Second packet on SID 5 → `new_stream_id` = 0 and `enable` = 1 held from LOAD through EOP.
- Packet on SID 9 with its mask bit at 0 → `enable` = 0, `eop` still issued, `seen[9]` stays 0, and the next SID 9 packet again shows `new_stream_id` = 1.
- 1-byte packet (first beat carries `s_last`), then a back-to-back header already pending → `hdr_rdy` rises the cycle after EOP and `load_state` follows one cycle later.
- `rst` asserted in STREAM after 2 of 6 bytes → no `eop`, outputs at reset values the next cycle, and a following packet on the same SID reports `new_stream_id` = 1.
- With `DPI_SEQ_STATS_EN`: three packets of 3, 1 and 5 bytes → `pkt_cnt` = 3 and `byte_cnt` = 9.
